// File: rtl/ballot_collector_pkg.sv
// Shared types and constants for the ballot collector: frame header codes,
// FSM/class encodings, bus widths and a one-hot decode helper.
package vote_pkg;

   localparam int NP_W  = 32;
   localparam int VIP_W = 8;
   localparam int CNT_W = 8;

   localparam logic [7:0] HDR_NP_CODE   = 8'hA0;
   localparam logic [7:0] HDR_VIP_CODE  = 8'hB0;
   localparam logic [7:0] HDR_VVIP_CODE = 8'hC0;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_ID   = 2'd1,
      ST_EMIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CL_NP   = 2'd0,
      CL_VIP  = 2'd1,
      CL_VVIP = 2'd2
   } class_e;

   function automatic logic [NP_W-1:0] onehot32(input logic [4:0] idx);
      logic [NP_W-1:0] v;
      v      = {NP_W{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/ballot_collector_if.sv
// Byte-serial valid/ready ballot link between a ballot source and the collector.
interface ballot_collector_if;

   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/ballot_collector_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
   import vote_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count register: clear wins over increment, increment stops at saturation
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= {W{1'b0}};
      end else if (clr) begin
         count <= {W{1'b0}};
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + {{(W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/ballot_collector.sv
// Ballot collector: validates header/ID frames, suppresses repeat voters per
// session and emits one-cycle one-hot pulses for the weighted vote tallier.
module ballot_collector
   import vote_pkg::*;
#(
   parameter int         TIMEOUT  = 16,
   parameter logic [7:0] HDR_NP   = HDR_NP_CODE,
   parameter logic [7:0] HDR_VIP  = HDR_VIP_CODE,
   parameter logic [7:0] HDR_VVIP = HDR_VVIP_CODE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               session_clr,
   ballot_collector_if.slave  link,
   output logic [NP_W-1:0]    np,
   output logic [VIP_W-1:0]   vip,
   output logic               vvip,
   output logic [CNT_W-1:0]   acc_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [CNT_W-1:0]   dup_cnt
);

   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e             state_r;
   state_e             state_s;
   class_e             class_r;
   class_e             hdr_class_s;
   logic [TMO_W-1:0]   tmo_r;
   logic [NP_W-1:0]    np_seen_r;
   logic [VIP_W-1:0]   vip_seen_r;
   logic               vvip_seen_r;
   logic [NP_W-1:0]    np_mask_r;
   logic [VIP_W-1:0]   vip_mask_r;
   logic               vvip_mask_r;
   logic               hdr_ok_s;
   logic               id_ok_s;
   logic               id_seen_s;
   logic               xfer_s;
   logic               tmo_done_s;
   logic               in_ready_s;
   logic               acc_inc_s;
   logic               err_inc_s;
   logic               dup_inc_s;

   // A session restart blocks the link for its cycle, so no byte is consumed
   assign xfer_s     = link.in_valid && !session_clr && (state_r != ST_EMIT);
   assign tmo_done_s = (tmo_r == TMO_W'(TIMEOUT - 1));
   assign link.in_ready = in_ready_s;

   // Header classification and ID range / repeat lookup for the latched class
   always_comb begin
      hdr_ok_s    = 1'b1;
      hdr_class_s = CL_NP;
      id_ok_s     = 1'b0;
      id_seen_s   = 1'b0;
      case (link.in_data)
         HDR_NP:   hdr_class_s = CL_NP;
         HDR_VIP:  hdr_class_s = CL_VIP;
         HDR_VVIP: hdr_class_s = CL_VVIP;
         default:  hdr_ok_s    = 1'b0;
      endcase
      case (class_r)
         CL_NP: begin
            id_ok_s   = (link.in_data < 8'd32);
            id_seen_s = np_seen_r[link.in_data[4:0]];
         end
         CL_VIP: begin
            id_ok_s   = (link.in_data < 8'd8);
            id_seen_s = vip_seen_r[link.in_data[2:0]];
         end
         CL_VVIP: begin
            id_ok_s   = (link.in_data == 8'd0);
            id_seen_s = vvip_seen_r;
         end
         default: begin
            id_ok_s   = 1'b0;
            id_seen_s = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_HDR;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      if (session_clr) begin
         state_s = ST_HDR;
      end else begin
         case (state_r)
            ST_HDR: begin
               if (xfer_s && hdr_ok_s) begin
                  state_s = ST_ID;
               end else begin
                  state_s = ST_HDR;
               end
            end
            ST_ID: begin
               if (xfer_s) begin
                  state_s = (id_ok_s && !id_seen_s) ? ST_EMIT : ST_HDR;
               end else if (tmo_done_s) begin
                  state_s = ST_HDR;
               end else begin
                  state_s = ST_ID;
               end
            end
            ST_EMIT: state_s = ST_HDR;
            default: state_s = ST_HDR;
         endcase
      end
   end

   // FSM outputs: link ready, tallier pulses and statistic events
   always_comb begin
      in_ready_s = 1'b0;
      np         = {NP_W{1'b0}};
      vip        = {VIP_W{1'b0}};
      vvip       = 1'b0;
      acc_inc_s  = 1'b0;
      err_inc_s  = 1'b0;
      dup_inc_s  = 1'b0;
      if (session_clr) begin
         in_ready_s = 1'b0;
      end else begin
         case (state_r)
            ST_HDR: begin
               in_ready_s = 1'b1;
               err_inc_s  = xfer_s && !hdr_ok_s;
            end
            ST_ID: begin
               in_ready_s = 1'b1;
               err_inc_s  = xfer_s ? !id_ok_s : tmo_done_s;
               dup_inc_s  = xfer_s && id_ok_s && id_seen_s;
            end
            ST_EMIT: begin
               np        = np_mask_r;
               vip       = vip_mask_r;
               vvip      = vvip_mask_r;
               acc_inc_s = 1'b1;
            end
            default: begin
               in_ready_s = 1'b0;
            end
         endcase
      end
   end

   // Frame context, ID-wait timer, pending pulse mask and per-class seen bitmaps
   always_ff @(posedge clk) begin
      if (!reset || session_clr) begin
         class_r     <= CL_NP;
         tmo_r       <= {TMO_W{1'b0}};
         np_seen_r   <= {NP_W{1'b0}};
         vip_seen_r  <= {VIP_W{1'b0}};
         vvip_seen_r <= 1'b0;
         np_mask_r   <= {NP_W{1'b0}};
         vip_mask_r  <= {VIP_W{1'b0}};
         vvip_mask_r <= 1'b0;
      end else begin
         case (state_r)
            ST_HDR: begin
               if (xfer_s && hdr_ok_s) begin
                  class_r <= hdr_class_s;
                  tmo_r   <= {TMO_W{1'b0}};
               end
            end
            ST_ID: begin
               if (xfer_s) begin
                  tmo_r <= {TMO_W{1'b0}};
                  if (id_ok_s && !id_seen_s) begin
                     np_mask_r   <= (class_r == CL_NP) ? onehot32(link.in_data[4:0])
                                                       : {NP_W{1'b0}};
                     vip_mask_r  <= (class_r == CL_VIP) ? VIP_W'(onehot32({2'b00, link.in_data[2:0]}))
                                                        : {VIP_W{1'b0}};
                     vvip_mask_r <= (class_r == CL_VVIP);
                  end
               end else if (tmo_done_s) begin
                  tmo_r <= {TMO_W{1'b0}};
               end else begin
                  tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
               end
            end
            ST_EMIT: begin
               np_seen_r   <= np_seen_r | np_mask_r;
               vip_seen_r  <= vip_seen_r | vip_mask_r;
               vvip_seen_r <= vvip_seen_r | vvip_mask_r;
               np_mask_r   <= {NP_W{1'b0}};
               vip_mask_r  <= {VIP_W{1'b0}};
               vvip_mask_r <= 1'b0;
            end
            default: begin
               tmo_r <= {TMO_W{1'b0}};
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_acc_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (session_clr),
      .inc   (acc_inc_s),
      .count (acc_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (session_clr),
      .inc   (err_inc_s),
      .count (err_cnt)
   );

   sat_counter #(.W(CNT_W)) u_dup_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (session_clr),
      .inc   (dup_inc_s),
      .count (dup_cnt)
   );

endmodule
